alu_muldiv: RTL and testbench

Parametrised successor to the processor's single-cycle ALU. It keeps the combinational ALU path: logic, add/sub, slt, shifts, low-bit clear and the signed branch compare. It adds an iterative multiply/divide unit with HI/LO registers and a start/busy/done handshake. It sits in the datapath in place of the single-cycle ALU; the controller stalls on `busy`.

---
 rtl/alu_muldiv_if.sv | 23 ++
 rtl/alu_muldiv.sv | 175 +++++++++++++++++
 tb/tb_alu_muldiv.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - operand, control and result bundle between datapath and alu_muldiv
interface alu_muldiv_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [SHW-1:0]   shamt;
   logic [3:0]       alucontrol;
   logic             start;
   logic [1:0]       mdop;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output a, b, shamt, alucontrol, start, mdop,
                   input  result, zero, busy, done, hi, lo);
   modport slave  (input  a, b, shamt, alucontrol, start, mdop,
                   output result, zero, busy, done, hi, lo);
endinterface

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - combinational ALU plus iterative mult/div with HI/LO, unit built when ALU_MULDIV_EN is defined
module alu_muldiv #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic        clk,
   input  logic        reset,
   alu_muldiv_if.slave bus
);
   logic [WIDTH-1:0] sum;
   logic [SHW:0]     clr_cnt;
   logic [WIDTH-1:0] clr_mask;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] hi_v;
   logic [WIDTH-1:0] lo_v;
   logic             busy_v;
   logic             done_v;

   // Single-cycle ALU: every code decodes straight from the inputs
   always_comb begin
      sum      = bus.a + (bus.alucontrol[3] ? ~bus.b : bus.b)
                 + {{(WIDTH-1){1'b0}}, bus.alucontrol[3]};
      clr_cnt  = {1'b0, bus.b[SHW-1:0]} + {{SHW{1'b0}}, 1'b1};
      // a shift by the full width yields an all-zero mask
      clr_mask = {WIDTH{1'b1}} << clr_cnt;
      result   = '0;
      case (bus.alucontrol)
         4'b0000: result = bus.a & bus.b;
         4'b0001: result = bus.a | bus.b;
         4'b1101: result = bus.a ^ bus.b;
         4'b0010,
         4'b1010: result = sum;
         4'b0011,
         4'b1011: result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
         4'b0100: result = bus.b << bus.shamt;
         4'b0111: result = bus.b >> bus.shamt;
         4'b1100: result = $signed(bus.b) >>> bus.shamt;
         4'b0110: result = bus.a & clr_mask;
         4'b1110: result = hi_v;
         4'b1111: result = lo_v;
         default: result = '0;
      endcase
   end

   assign bus.result = result;
   assign bus.zero   = (bus.alucontrol == 4'b0101) ? ($signed(bus.a) <= $signed(bus.b))
                                                   : (result == '0);
   assign bus.hi     = hi_v;
   assign bus.lo     = lo_v;
   assign bus.busy   = busy_v;
   assign bus.done   = done_v;

`ifdef ALU_MULDIV_EN
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state_q, state_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic               div_q, div_d;
   logic               neg_a_q, neg_a_d;
   logic               neg_b_q, neg_b_d;
   logic [WIDTH-1:0]   mb_q, mb_d;
   // {upper, lower}: multiply = {accumulator, multiplier}; divide = {remainder, quotient}
   logic [2*WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic [WIDTH:0]     acc_add;
   logic [WIDTH:0]     r_sh;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   // Next-state and iteration datapath: magnitude math in RUN, signs restored in FIX
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      mb_d    = mb_q;
      p_d     = p_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      acc_add = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mb_q} : '0);
      r_sh    = p_q[2*WIDTH-1:WIDTH-1];
      diff    = r_sh - {1'b0, mb_q};
      prod    = (neg_a_q ^ neg_b_q) ? -p_q : p_q;
      quo     = (neg_a_q ^ neg_b_q) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
      rem     = neg_a_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               cnt_d   = '0;
               div_d   = bus.mdop[1];
               neg_a_d = bus.mdop[0] & bus.a[WIDTH-1];
               neg_b_d = bus.mdop[0] & bus.b[WIDTH-1];
               mb_d    = (bus.mdop[0] & bus.b[WIDTH-1]) ? -bus.b : bus.b;
               p_d     = {{WIDTH{1'b0}},
                          ((bus.mdop[0] & bus.a[WIDTH-1]) ? -bus.a : bus.a)};
            end
         end
         RUN: begin
            if (!div_q)
               p_d = {acc_add, p_q[WIDTH-1:1]};
            else if (!diff[WIDTH])
               p_d = {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
            else
               p_d = {r_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
            if (cnt_q == {SHW{1'b1}})
               state_d = FIX;
         end
         FIX: begin
            if (!div_q) begin
               {hi_d, lo_d} = prod;
            end else begin
               // with a zero divisor the register just shifts, so the remainder half
               // ends up holding |a| and the sign fix-up returns a unchanged
               hi_d = rem;
               lo_d = (mb_q == '0) ? '1 : quo;
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset aborts any operation in flight and clears HI/LO
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         mb_q    <= '0;
         p_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         mb_q    <= mb_d;
         p_q     <= p_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign hi_v   = hi_q;
   assign lo_v   = lo_q;
   assign busy_v = (state_q != IDLE);
   assign done_v = done_q;
`else
   logic unused_ok;

   assign hi_v      = '0;
   assign lo_v      = '0;
   assign busy_v    = 1'b0;
   assign done_v    = 1'b0;
   assign unused_ok = ^{clk, reset, bus.start, bus.mdop};
`endif
endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - self-checking bench for alu_muldiv against a behavioural model
module tb_alu_muldiv;
   localparam int W = 32;
`ifdef ALU_MULDIV_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   checking = 1'b0;

   alu_muldiv_if #(.WIDTH(W)) bus ();
   alu_muldiv #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // model state
   logic        m_busy, m_done;
   logic [31:0] m_hi, m_lo;
   logic [63:0] m_pend;
   int          m_left;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // reference {hi, lo} of a mult/div from plain 64-bit arithmetic
   function automatic logic [63:0] md_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
      longint sa, sb, p;
      logic [31:0] q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: return {32'b0, a} * {32'b0, b};
         2'b01: begin p = sa * sb; return p; end
         2'b10: begin
            if (b == 0) begin q = '1; r = a; end
            else begin q = a / b; r = a % b; end
         end
         default: begin
            if (b == 0) begin q = '1; r = a; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = a; r = 0; end
            else begin q = 32'(sa / sb); r = 32'(sa % sb); end
         end
      endcase
      return {r, q};
   endfunction

   task automatic alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                          input logic [3:0] c, input logic [31:0] hv, input logic [31:0] lv,
                          output logic [31:0] r, output logic z);
      logic [31:0] t;
      int n;
      case (c)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd13: r = a ^ b;
         4'd2:  r = a + b;
         4'd10: r = a - b;
         4'd3:  begin t = a + b; r = {31'b0, t[31]}; end
         4'd11: begin t = a - b; r = {31'b0, t[31]}; end
         4'd4:  r = b << sh;
         4'd7:  r = b >> sh;
         4'd12: r = $signed(b) >>> sh;
         4'd6:  begin n = int'(b[4:0]) + 1; r = (n == 32) ? 32'h0 : ((a >> n) << n); end
         4'd14: r = hv;
         4'd15: r = lv;
         default: r = 32'h0;
      endcase
      z = (c == 4'd5) ? ($signed(a) <= $signed(b)) : (r == 32'h0);
   endtask

   // behavioural timing model: an op accepted while idle completes WIDTH+1 edges later
   always @(posedge clk) begin
      if (reset) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               {m_hi, m_lo} <= m_pend;
               m_done <= 1'b1;
               m_busy <= 1'b0;
            end
         end else if (EN && bus.start) begin
            m_pend <= md_ref(bus.a, bus.b, bus.mdop);
            m_left <= W + 1;
            m_busy <= 1'b1;
         end
      end
   end

   // compare process: all outputs against the model every cycle
   always @(negedge clk) begin
      logic [31:0] er;
      logic ez;
      if (checking) begin
         alu_ref(bus.a, bus.b, bus.shamt, bus.alucontrol, m_hi, m_lo, er, ez);
         chk("result", bus.result, er);
         chk("zero", bus.zero, ez);
         chk("busy", bus.busy, m_busy);
         chk("done", bus.done, m_done);
         chk("hi", bus.hi, m_hi);
         chk("lo", bus.lo, m_lo);
         if (bus.busy && bus.done) chk("busy_done_overlap", 1, 0);
      end
   end

   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic [1:0] op,
                         output int lat, output int bc);
      bus.a = ta; bus.b = tb_v; bus.mdop = op; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      lat = -1; bc = 0;
      for (int n = 0; n < 60; n++) begin
         if (bus.done) begin lat = n; break; end
         if (bus.busy) bc++;
         step();
      end
   endtask

   task automatic comb(input logic [31:0] ta, input logic [31:0] tb_v, input logic [4:0] sh,
                       input logic [3:0] c);
      bus.a = ta; bus.b = tb_v; bus.shamt = sh; bus.alucontrol = c;
      #1;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int lat, bc, dones;
      reset = 1'b1;
      bus.a = '0; bus.b = '0; bus.shamt = '0; bus.alucontrol = '0;
      bus.start = 1'b0; bus.mdop = '0;
      repeat (3) step();
      reset = 1'b0;
      checking = 1'b1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_hi", bus.hi, 0);
      chk("rst_lo", bus.lo, 0);

      comb(5, 7, 0, 4'b1010);
      chk("sub", bus.result, 32'hFFFF_FFFE);
      chk("sub_zero", bus.zero, 0);
      comb(5, 7, 0, 4'b1011);
      chk("slt", bus.result, 1);
      comb(5, 7, 0, 4'b0010);
      chk("add", bus.result, 12);
      comb(5, 7, 0, 4'b0101);
      chk("ble_true", bus.zero, 1);
      comb(7, 5, 0, 4'b0101);
      chk("ble_false", bus.zero, 0);
      comb(32'hFFFF_FFFF, 3, 0, 4'b0110);
      chk("clr4", bus.result, 32'hFFFF_FFF0);
      comb(32'hFFFF_FFFF, 31, 0, 4'b0110);
      chk("clr32", bus.result, 0);
      chk("clr32_zero", bus.zero, 1);
      comb(0, 32'h8000_0000, 4, 4'b0111);
      chk("srl", bus.result, 32'h0800_0000);
      comb(0, 32'h8000_0000, 4, 4'b1100);
      chk("sra", bus.result, 32'hF800_0000);
      comb(0, 1, 31, 4'b0100);
      chk("sll", bus.result, 32'h8000_0000);

      bus.alucontrol = 4'b0000;
      run_op(32'hFFFF_FFFD, 7, 2'b01, lat, bc);
      chk("mult_latency", lat, EN ? 33 : -1);
      chk("mult_busy_cycles", bc, EN ? 33 : 0);
      chk("mult_hi", bus.hi, EN ? 32'hFFFF_FFFF : 0);
      chk("mult_lo", bus.lo, EN ? 32'hFFFF_FFEB : 0);

      run_op(-7, 2, 2'b11, lat, bc);
      chk("div_b2b_latency", lat, EN ? 33 : -1);
      chk("div_lo", bus.lo, EN ? 32'hFFFF_FFFD : 0);
      chk("div_hi", bus.hi, EN ? 32'hFFFF_FFFF : 0);
      run_op(9, 0, 2'b10, lat, bc);
      chk("divu0_lo", bus.lo, EN ? 32'hFFFF_FFFF : 0);
      chk("divu0_hi", bus.hi, EN ? 9 : 0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b11, lat, bc);
      chk("divovf_lo", bus.lo, EN ? 32'h8000_0000 : 0);
      chk("divovf_hi", bus.hi, 0);
      step();

      bus.alucontrol = 4'b1111;
      bus.a = 32'h0001_0000; bus.b = 32'h0001_0000; bus.mdop = 2'b00; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      dones = 0;
      for (int n = 0; n < 45; n++) begin
         if (n == 5) begin bus.start = 1'b1; bus.a = '1; bus.b = '1; end
         if (n == 6) bus.start = 1'b0;
         if (n == 10) chk("lo_read_busy", bus.result, EN ? 32'h8000_0000 : 0);
         if (bus.done) dones++;
         step();
      end
      chk("midop_dones", dones, EN ? 1 : 0);
      chk("midop_hi", bus.hi, EN ? 1 : 0);
      chk("midop_lo", bus.lo, 0);

      bus.a = 3; bus.b = 3; bus.mdop = 2'b00; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (10) step();
      chk("busy_before_reset", bus.busy, EN);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_hi", bus.hi, 0);
      chk("abort_lo", bus.lo, 0);
      dones = 0;
      repeat (40) begin
         if (bus.done) dones++;
         step();
      end
      chk("abort_dones", dones, 0);

      for (int i = 0; i < 1500; i++) begin
         bus.a          = pick();
         bus.b          = pick();
         bus.shamt      = 5'($urandom);
         bus.alucontrol = 4'($urandom);
         bus.mdop       = 2'($urandom);
         bus.start      = ($urandom_range(0, 7) == 0);
         reset          = ($urandom_range(0, 299) == 0);
         step();
      end
      reset = 1'b0;
      bus.start = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
